// File: rtl/axis_packet_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_packet_fifo_if
// Purpose  : AXI-Stream beat bundle (tvalid/tready/tdata/tlast) shared by the
//            slave (arbiter-facing) and master (consumer-facing) ports of
//            axis_packet_fifo.
// Ports    : tvalid  - beat valid, driven by the master side
//            tready  - beat accepted, driven by the slave side
//            tdata   - DATA_WIDTH beat payload, driven by the master side
//            tlast   - end-of-packet marker, driven by the master side
// Revision : 1.0 - initial release
// ============================================================================
interface axis_packet_fifo_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tlast;

   // Side that sources beats.
   modport master (
      output tvalid,
      output tdata,
      output tlast,
      input  tready
   );

   // Side that sinks beats.
   modport slave (
      input  tvalid,
      input  tdata,
      input  tlast,
      output tready
   );
endinterface
`default_nettype wire

// File: rtl/axis_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axis_packet_fifo
// Purpose  : Store-and-forward AXI-Stream packet FIFO. A packet is offered on
//            the master port only once its tlast beat has been stored, so the
//            consumer sees gap-free packets. A packet longer than the FIFO
//            falls back to cut-through streaming to avoid deadlock.
// Ports    : axis_clk   - single clock, rising edge
//            resetn     - asynchronous assert, synchronous release, active low
//            s_axis     - slave beat port (from the round-robin arbiter)
//            m_axis     - master beat port (to the downstream consumer)
//            fill_level - number of stored beats, 0..DEPTH
//            pkt_count  - number of complete packets stored
// Revision : 1.0 - initial release
// ============================================================================
module axis_packet_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                     axis_clk,
   input  logic                     resetn,
   axis_packet_fifo_if.slave        s_axis,
   axis_packet_fifo_if.master       m_axis,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic [$clog2(DEPTH):0]   pkt_count
);

   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] ZERO_LEVEL = '0;

   // Forwarding mode: normal store-and-forward, or cut-through while an
   // oversize packet is draining.
   typedef enum logic [0:0] {
      ST_STORE_FWD = 1'b0,
      ST_CUT_THRU  = 1'b1
   } state_t;

   state_t state;
   state_t state_next;

   // {tlast, tdata} per entry; contents are intentionally not reset.
   logic [DATA_WIDTH:0]   mem [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   fill_next;
   logic [ADDR_WIDTH:0]   pkt_next;

   logic                  push;
   logic                  pop;
   logic                  push_last;
   logic                  pop_last;
   logic                  out_valid;
   logic                  cut_through;
   logic [DATA_WIDTH:0]   head_word;

   // ------------------------------------------------------------------------
   // Handshakes. Ready depends only on registered fill so a pop in the full
   // cycle does not create space until the following cycle. Gating with
   // resetn holds ready low for the whole reset interval.
   // ------------------------------------------------------------------------
   assign s_axis.tready = resetn && (fill_level != FULL_LEVEL);
   assign push          = s_axis.tvalid && s_axis.tready;
   assign push_last     = push && s_axis.tlast;

   assign cut_through   = (state == ST_CUT_THRU);
   assign out_valid     = (fill_level != ZERO_LEVEL) &&
                          ((pkt_count != ZERO_LEVEL) || cut_through);

   assign head_word     = mem[rd_ptr];
   assign pop           = out_valid && m_axis.tready;
   assign pop_last      = pop && head_word[DATA_WIDTH];

   assign m_axis.tvalid = out_valid;
   assign m_axis.tdata  = out_valid ? head_word[DATA_WIDTH-1:0] : '0;
   assign m_axis.tlast  = out_valid && head_word[DATA_WIDTH];

   // ------------------------------------------------------------------------
   // Storage write port
   // ------------------------------------------------------------------------
   always_ff @(posedge axis_clk) begin
      if (push) begin
         mem[wr_ptr] <= {s_axis.tlast, s_axis.tdata};
      end
   end

   // ------------------------------------------------------------------------
   // Occupancy and packet accounting
   // ------------------------------------------------------------------------
   always_comb begin
      fill_next = fill_level;
      case ({push, pop})
         2'b10:   fill_next = fill_level + 1'b1;
         2'b01:   fill_next = fill_level - 1'b1;
         default: fill_next = fill_level;
      endcase
   end

   always_comb begin
      pkt_next = pkt_count;
      case ({push_last, pop_last})
         2'b10:   pkt_next = pkt_count + 1'b1;
         2'b01:   pkt_next = pkt_count - 1'b1;
         default: pkt_next = pkt_count;
      endcase
   end

   // Pointers are ADDR_WIDTH bits wide, so wrap modulo DEPTH falls out of
   // the natural overflow (DEPTH is a power of two).
   always_ff @(posedge axis_clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
         pkt_count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         fill_level <= fill_next;
         pkt_count  <= pkt_next;
      end
   end

   // ------------------------------------------------------------------------
   // Forwarding-mode FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge axis_clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_STORE_FWD;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_STORE_FWD: begin
            // Full with no complete packet: the stored beats belong to a
            // packet that can never finish unless we start draining it.
            if ((fill_level == FULL_LEVEL) && (pkt_count == ZERO_LEVEL)) begin
               state_next = ST_CUT_THRU;
            end
         end
         ST_CUT_THRU: begin
            // The oversize packet ends when its tlast beat leaves.
            if (pop_last) begin
               state_next = ST_STORE_FWD;
            end
         end
         default: state_next = ST_STORE_FWD;
      endcase
   end

endmodule
`default_nettype wire

// File: doc/axis_packet_fifo.md
Name: axis_packet_fifo

Overview:
- Store-and-forward AXI-Stream packet FIFO directly downstream of the two-input round-robin arbiter.
- Consumes the arbiter's merged 8-bit stream and presents a packet on its master port only once that packet's tlast beat is stored.
- Gives the downstream consumer contiguous, gap-free packets and absorbs arbiter bursts while the consumer stalls.

Parameters:
- DATA_WIDTH, 8, width of tdata on both ports.
- DEPTH, 16, number of beat entries; power of two, minimum 2.
- ADDR_WIDTH, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- axis_clk  in  1  single clock; all logic is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- s_axis_tvalid  in  1  beat valid from the arbiter.
- s_axis_tready  out  1  FIFO can accept a beat.
- s_axis_tdata  in  DATA_WIDTH  beat data.
- s_axis_tlast  in  1  last beat of a packet.
- m_axis_tvalid  out  1  beat available to the consumer.
- m_axis_tready  in  1  consumer accepts the beat.
- m_axis_tdata  out  DATA_WIDTH  head beat data.
- m_axis_tlast  out  1  head beat is the end of its packet.
- fill_level  out  ADDR_WIDTH+1  number of stored beats, 0..DEPTH.
- pkt_count  out  ADDR_WIDTH+1  number of complete packets stored.

Behaviour:
- Reset (resetn=0, async assert, sync release):
  - wr_ptr, rd_ptr, fill_level, pkt_count and the cut_through flag all clear to 0.
  - s_axis_tready=1 once reset is released. It is 0 while resetn=0.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - Memory contents are not reset.
  - Reset mid-packet discards every stored beat, including partial packets.
- Storage:
  - DEPTH x (DATA_WIDTH+1) array holding {tlast, tdata}.
  - Pointers wrap modulo DEPTH.
  - fill_level is a registered up/down count.
- push = s_axis_tvalid && s_axis_tready.
  - On push, write the beat at wr_ptr and increment wr_ptr.
- pop = m_axis_tvalid && m_axis_tready.
  - On pop, increment rd_ptr.
- s_axis_tready = (fill_level != DEPTH), from registered state only.
  - When full it stays 0 even if a pop occurs in the same cycle; space appears the next cycle.
- fill_level next value:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, or when neither occurs.
- pkt_count next value:
  - +1 on a push with tlast=1.
  - -1 on a pop with tlast=1.
  - Unchanged when both occur in the same cycle.
- Release rule: m_axis_tvalid = (fill_level != 0) && (pkt_count != 0 || cut_through).
- Latency:
  - A packet whose tlast is pushed at edge N shows m_axis_tvalid=1 after edge N. The first beat is presented in cycle N+1.
  - Beats already stored stream back-to-back while m_axis_tready=1.
- Output data:
  - m_axis_tdata and m_axis_tlast are read combinationally from mem[rd_ptr].
  - Both are forced to 0 whenever m_axis_tvalid=0.
- Oversize packets (longer than DEPTH):
  - cut_through sets when fill_level==DEPTH && pkt_count==0. This prevents deadlock.
  - While cut_through is set, the FIFO streams in cut-through mode: m_axis_tvalid = (fill_level != 0).
  - cut_through clears on the pop of a tlast=1 beat. After that, store-and-forward resumes.
  - A push with tlast=1 while cut_through is set still increments pkt_count.
  - The clearing pop decrements pkt_count.
- Empty with simultaneous push: no pop is possible, because valid is 0.
- Handshake rules:
  - Once m_axis_tvalid=1, it and the head data hold stable until the pop.
  - The release rule never retracts valid: pkt_count>0 only drops via a pop.
  - The upstream arbiter may toggle tvalid freely; only accepted beats are stored.

Test Plan:
1. Single packet: push 0xA1,0xA2,0xA3,0xA4 (tlast on 0xA4), m_axis_tready=1 -> m_axis_tvalid stays 0 until the cycle after the 0xA4 push, then 4 consecutive beats 0xA1..0xA4 with tlast only on 0xA4; pkt_count goes 0->1->0, fill_level ends 0.
2. Back-pressure: two 3-beat packets stored, m_axis_tready=0 for 10 cycles -> m_axis_tvalid=1 and tdata stable at the first beat; fill_level=6, pkt_count=2; on release, 6 beats in order with no gaps.
3. Full boundary, DEPTH=16: push 16 beats forming 4 packets with the consumer stalled -> s_axis_tready=0 at fill_level=16; one pop -> s_axis_tready=1 the following cycle, and the 17th beat is accepted.
4. Oversize packet: 20-beat packet with the consumer stalled until full -> cut_through sets, beats 1..16 drain, beats 17..20 stream through, tlast on beat 20, cut_through clears, pkt_count=0.
5. Simultaneous push/pop: FIFO holds 1 packet of 2 beats; push a tlast beat while popping a tlast beat -> pkt_count unchanged and fill_level unchanged in that cycle.
6. Reset mid-packet: 5 beats of an unfinished packet stored, assert resetn=0 for 1 cycle -> all outputs 0 immediately, fill_level=0, pkt_count=0; a fresh 2-beat packet afterward emerges intact.
